// File: rtl/sobel_row_window_if.sv
// Handshake bundle between the Sobel read stage, row window and write stage.
// slave: row window side; master: surrounding read/control/write stages.
interface sobel_row_window_if #(
   parameter int ACC_N = 8,
   parameter int PIX_W = 8,
   parameter int CNT_W = 16
);
   localparam int IDATA_W = (ACC_N + 2) * PIX_W;

   logic               sctl2srow_strip_start;
   logic               srd2srow_valid;
   logic [IDATA_W-1:0] srd2srow_data;
   logic               srow2srd_ready;
   logic [IDATA_W-1:0] srow2sacc_row1_data;
   logic [IDATA_W-1:0] srow2sacc_row2_data;
   logic [IDATA_W-1:0] srow2sacc_row3_data;
   logic               srow2swt_valid;
   logic               swt2srow_ready;
   logic [CNT_W-1:0]   srow2swt_win_idx;

   modport slave (
      input  sctl2srow_strip_start,
      input  srd2srow_valid,
      input  srd2srow_data,
      output srow2srd_ready,
      output srow2sacc_row1_data,
      output srow2sacc_row2_data,
      output srow2sacc_row3_data,
      output srow2swt_valid,
      input  swt2srow_ready,
      output srow2swt_win_idx
   );

   modport master (
      output sctl2srow_strip_start,
      output srd2srow_valid,
      output srd2srow_data,
      input  srow2srd_ready,
      input  srow2sacc_row1_data,
      input  srow2sacc_row2_data,
      input  srow2sacc_row3_data,
      input  srow2swt_valid,
      output swt2srow_ready,
      input  srow2swt_win_idx
   );
endinterface

// File: rtl/sobel_row_window.sv
// 3-row sliding window feeding the Sobel accelerator cores.
// Optional SOBEL_ROW_TOP_REPLICATE_EN: first slice of a strip fills all rows.
module sobel_row_window #(
   parameter int ACC_N   = 8,
   parameter int PIX_W   = 8,
   parameter int IDATA_W = (ACC_N + 2) * PIX_W,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   sobel_row_window_if.slave   bus
);

   typedef enum logic [2:0] {
      FILL0,
      FILL1,
      FILL2,
      VALID,
      STALE
   } state_t;

   state_t             r_state;
   state_t             w_nxt_state;
   logic               r_valid;
   logic [IDATA_W-1:0] r_row1;
   logic [IDATA_W-1:0] r_row2;
   logic [IDATA_W-1:0] r_row3;
   logic [CNT_W-1:0]   r_win_idx;

   logic               w_ready;
   logic               w_accept;
   logic               w_consume;
   logic               w_strip;

   // ready only drops while a window waits on the write stage
   assign w_ready   = (r_state != VALID) | bus.swt2srow_ready;
   assign w_accept  = bus.srd2srow_valid & w_ready;
   assign w_consume = (r_state == VALID) & bus.swt2srow_ready;
   assign w_strip   = bus.sctl2srow_strip_start;

   assign bus.srow2srd_ready      = w_ready;
   assign bus.srow2swt_valid      = r_valid;
   assign bus.srow2sacc_row1_data = r_row1;
   assign bus.srow2sacc_row2_data = r_row2;
   assign bus.srow2sacc_row3_data = r_row3;
   assign bus.srow2swt_win_idx    = r_win_idx;

   // next-state decode; strip start overrides any handshake
   always_comb begin
      w_nxt_state = r_state;
      if (w_strip) begin
         w_nxt_state = FILL0;
      end else begin
         unique case (r_state)
            FILL0: begin
               if (w_accept) begin
`ifdef SOBEL_ROW_TOP_REPLICATE_EN
                  w_nxt_state = FILL2;
`else
                  w_nxt_state = FILL1;
`endif
               end
            end
            FILL1: begin
               if (w_accept) w_nxt_state = FILL2;
            end
            FILL2: begin
               if (w_accept) w_nxt_state = VALID;
            end
            VALID: begin
               if (bus.swt2srow_ready && !w_accept)
                  w_nxt_state = STALE;
            end
            STALE: begin
               if (w_accept) w_nxt_state = VALID;
            end
            default: w_nxt_state = FILL0;
         endcase
      end
   end

   // state register with registered valid decode
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= FILL0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_valid <= (w_nxt_state == VALID);
      end
   end

   // row shift on accept; a slice arriving with strip start is dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_row1 <= '0;
         r_row2 <= '0;
         r_row3 <= '0;
      end else if (w_accept && !w_strip) begin
`ifdef SOBEL_ROW_TOP_REPLICATE_EN
         if (r_state == FILL0) begin
            r_row1 <= bus.srd2srow_data;
            r_row2 <= bus.srd2srow_data;
            r_row3 <= bus.srd2srow_data;
         end else begin
            r_row1 <= r_row2;
            r_row2 <= r_row3;
            r_row3 <= bus.srd2srow_data;
         end
`else
         r_row1 <= r_row2;
         r_row2 <= r_row3;
         r_row3 <= bus.srd2srow_data;
`endif
      end
   end

   // window index within the strip, wraps silently
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_win_idx <= '0;
      end else if (w_strip) begin
         r_win_idx <= '0;
      end else if (w_consume) begin
         r_win_idx <= r_win_idx + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_sobel_row_window.sv
// Scoreboard bench for sobel_row_window.
// Reference window model runs from observed handshakes at the negedge.
module tb_sobel_row_window;
   localparam int ACC_N   = 8;
   localparam int PIX_W   = 8;
   localparam int IDATA_W = (ACC_N + 2) * PIX_W;
   localparam int CNT_W   = 16;

   typedef struct {
      logic [IDATA_W-1:0] r1;
      logic [IDATA_W-1:0] r2;
      logic [IDATA_W-1:0] r3;
      logic [CNT_W-1:0]   idx;
   } win_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   sobel_row_window_if #(
      .ACC_N(ACC_N), .PIX_W(PIX_W), .CNT_W(CNT_W)
   ) bus ();

   sobel_row_window #(
      .ACC_N(ACC_N), .PIX_W(PIX_W),
      .IDATA_W(IDATA_W), .CNT_W(CNT_W)
   ) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   int n_chk = 0;
   int n_pass = 0;

   win_t               q[$];
   logic [IDATA_W-1:0] m_r1, m_r2, m_r3;
   int                 m_fill = 0;
   logic [CNT_W-1:0]   m_idx = '0;
   logic [IDATA_W-1:0] s[16];
   win_t               e;

   task automatic chk(input string tag,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, act, exp);
   endtask

   task automatic cyc(input logic v, input logic [IDATA_W-1:0] d,
                      input logic wr, input logic ss);
      @(posedge clk);
      #1;
      bus.srd2srow_valid        = v;
      bus.srd2srow_data         = d;
      bus.swt2srow_ready        = wr;
      bus.sctl2srow_strip_start = ss;
   endtask

   // model: windows pushed on accept, popped/compared on consume
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.srow2swt_valid && bus.swt2srow_ready) begin
            if (q.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = q.pop_front();
               chk("win_r1", bus.srow2sacc_row1_data, e.r1);
               chk("win_r2", bus.srow2sacc_row2_data, e.r2);
               chk("win_r3", bus.srow2sacc_row3_data, e.r3);
               chk("win_idx", bus.srow2swt_win_idx, e.idx);
            end
         end
         if (bus.sctl2srow_strip_start) begin
            q.delete();
            m_fill = 0;
            m_idx  = '0;
         end else if (bus.srd2srow_valid && bus.srow2srd_ready) begin
`ifdef SOBEL_ROW_TOP_REPLICATE_EN
            if (m_fill == 0) begin
               m_r1 = bus.srd2srow_data;
               m_r2 = bus.srd2srow_data;
               m_r3 = bus.srd2srow_data;
               m_fill = 2;
            end else begin
               m_r1 = m_r2;
               m_r2 = m_r3;
               m_r3 = bus.srd2srow_data;
               m_fill = 3;
            end
`else
            m_r1 = m_r2;
            m_r2 = m_r3;
            m_r3 = bus.srd2srow_data;
            if (m_fill < 3) m_fill++;
`endif
            if (m_fill == 3) begin
               q.push_back('{r1: m_r1, r2: m_r2, r3: m_r3, idx: m_idx});
               m_idx = m_idx + 1'b1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++)
         s[i] = {16'($urandom), $urandom, $urandom};
      bus.srd2srow_valid        = 1'b0;
      bus.srd2srow_data         = '0;
      bus.swt2srow_ready        = 1'b0;
      bus.sctl2srow_strip_start = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", bus.srow2swt_valid, 0);
      chk("rst_ready", bus.srow2srd_ready, 1);
      chk("rst_idx", bus.srow2swt_win_idx, 0);
      chk("rst_r1", bus.srow2sacc_row1_data, 0);
      chk("rst_r2", bus.srow2sacc_row2_data, 0);
      chk("rst_r3", bus.srow2sacc_row3_data, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // A, B, C then D, E streamed with ready high
      cyc(1, s[0], 1, 0);
      cyc(1, s[1], 1, 0);
      cyc(1, s[2], 1, 0);
      @(negedge clk);
`ifdef SOBEL_ROW_TOP_REPLICATE_EN
      chk("fill_valid", bus.srow2swt_valid, 1);
`else
      chk("fill_valid", bus.srow2swt_valid, 0);
`endif
      cyc(1, s[3], 1, 0);
      @(negedge clk);
`ifndef SOBEL_ROW_TOP_REPLICATE_EN
      chk("lat_valid", bus.srow2swt_valid, 1);
      chk("lat_r1", bus.srow2sacc_row1_data, s[0]);
      chk("lat_r2", bus.srow2sacc_row2_data, s[1]);
      chk("lat_r3", bus.srow2sacc_row3_data, s[2]);
      chk("lat_idx", bus.srow2swt_win_idx, 0);
`endif
      cyc(1, s[4], 1, 0);
      @(negedge clk);
      chk("str_valid", bus.srow2swt_valid, 1);
      chk("str_r3", bus.srow2sacc_row3_data, s[3]);

      // stall with a slice pending
      for (int i = 0; i < 5; i++) begin
         cyc(1, s[5], 0, 0);
         @(negedge clk);
         chk("stall_ready", bus.srow2srd_ready, 0);
         chk("stall_valid", bus.srow2swt_valid, 1);
         chk("stall_r1", bus.srow2sacc_row1_data, s[2]);
         chk("stall_r3", bus.srow2sacc_row3_data, s[4]);
      end
      cyc(1, s[5], 1, 0);
      @(negedge clk);
      chk("resume_ready", bus.srow2srd_ready, 1);
      cyc(0, '0, 1, 0);
      @(negedge clk);
      chk("resume_r3", bus.srow2sacc_row3_data, s[5]);

      // consume with no slice -> stale
      cyc(0, '0, 0, 0);
      @(negedge clk);
      chk("stale_valid", bus.srow2swt_valid, 0);
      chk("stale_ready", bus.srow2srd_ready, 1);
      cyc(1, s[6], 0, 0);
      cyc(0, '0, 0, 0);
      @(negedge clk);
      chk("restale_valid", bus.srow2swt_valid, 1);
      chk("restale_r1", bus.srow2sacc_row1_data, s[4]);
      chk("restale_r3", bus.srow2sacc_row3_data, s[6]);

      // strip start with accept and consume in VALID
      cyc(1, s[7], 1, 1);
      @(negedge clk);
      chk("ss_ready", bus.srow2srd_ready, 1);
      cyc(0, '0, 0, 0);
      @(negedge clk);
      chk("ss_valid", bus.srow2swt_valid, 0);
      chk("ss_idx", bus.srow2swt_win_idx, 0);
      chk("ss_r3", bus.srow2sacc_row3_data, s[6]);

      // new strip J, K (, L)
      cyc(1, s[8], 0, 0);
      cyc(1, s[9], 0, 0);
      cyc(0, '0, 0, 0);
      @(negedge clk);
`ifdef SOBEL_ROW_TOP_REPLICATE_EN
      chk("rep_valid", bus.srow2swt_valid, 1);
      chk("rep_r1", bus.srow2sacc_row1_data, s[8]);
      chk("rep_r2", bus.srow2sacc_row2_data, s[8]);
      chk("rep_r3", bus.srow2sacc_row3_data, s[9]);
      chk("rep_idx", bus.srow2swt_win_idx, 0);
      cyc(1, s[10], 1, 0);
`else
      chk("two_valid", bus.srow2swt_valid, 0);
      cyc(1, s[10], 0, 0);
`endif
      cyc(0, '0, 0, 0);
      @(negedge clk);
      chk("ns_valid", bus.srow2swt_valid, 1);
      chk("ns_r3", bus.srow2sacc_row3_data, s[10]);

      // consume, accept M, then async reset mid-strip
      cyc(0, '0, 1, 0);
      cyc(1, s[11], 0, 0);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("arst_valid", bus.srow2swt_valid, 0);
      chk("arst_ready", bus.srow2srd_ready, 1);
      chk("arst_idx", bus.srow2swt_win_idx, 0);
      chk("arst_r1", bus.srow2sacc_row1_data, 0);
      chk("arst_r3", bus.srow2sacc_row3_data, 0);
      bus.srd2srow_valid = 1'b0;
      bus.swt2srow_ready = 1'b0;
      q.delete();
      m_fill = 0;
      m_idx  = '0;
      @(posedge clk);
      #1 reset_n = 1'b1;

      // short stream after reset
      for (int i = 12; i < 16; i++) cyc(1, s[i], 1, 0);
      repeat (3) cyc(0, '0, 1, 0);
      @(negedge clk);
      chk("sb_empty", q.size(), 0);
      chk("end_valid", bus.srow2swt_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
